spi_slave_regfile: RTL and testbench
====================================

Name: spi_slave_regfile

Overview:
SPI responder (mode 0, MSB first) exposing a small byte-wide register bank to an external SPI master.
- Runs entirely in the system clock domain and oversamples sclk/cs_n/mosi.
- Two-byte frame: command byte {rw, addr}, then data byte.
- Local logic reads the bank through a flat bus and is notified of every SPI write.

Parameters:
NREGS, 4, number of 8-bit registers (1..128)
ADDR_W, 2, width of wr_addr; must satisfy 2**ADDR_W >= NREGS
RESET_VAL, 8'h00, reset value of every register

Ports:
clk  input  1  system clock
reset  input  1  asynchronous reset, active-low (asserted at 0)
sclk  input  1  SPI clock from master, asynchronous to clk
cs_n  input  1  SPI chip select, active-low
mosi  input  1  master-out data
miso  output  1  slave-out data; 0 when not driving
miso_oe  output  1  1 while selected; top-level tristate enable
regs_flat  output  8*NREGS  register bank; reg i at [8i+7:8i]
wr_strobe  output  1  1-clk pulse on each committed SPI write
wr_addr  output  ADDR_W  address of the last committed write
wr_data  output  8  data of the last committed write
rx_byte  output  8  last complete data byte received on mosi
rx_valid  output  1  1-clk pulse when rx_byte updates
frame_err  output  1  1-clk pulse on an aborted frame

Behaviour:
- Reset (reset=0, asynchronous):
  - all registers = RESET_VAL
  - state IDLE, counters 0
  - every output 0
- Input synchronisation:
  - sclk, cs_n and mosi each pass through 2 flops; sclk has a third flop for edge detection.
  - Detection latency is 3 clk.
  - Requirement: sclk high and low phases >= 4 clk each.
- States: IDLE, CMD, DATA, HOLD.
- IDLE:
  - waits for synced cs_n=0, then enters CMD with bit_cnt=0.
- CMD:
  - each sclk rise shifts mosi into rx_shift (MSB first) and increments bit_cnt.
  - On the 8th rise: latch rw=bit7, addr=bits[6:0]; valid = addr < NREGS.
  - Load tx_shift with regs[addr] if rw=0 and valid, else 8'h00.
  - Go to DATA, bit_cnt=0.
- DATA:
  - sclk rise: shift mosi in, bit_cnt++.
  - sclk fall with bit_cnt>=1: tx_shift shifts left.
  - On the 8th rise: rx_byte<=rx_shift, rx_valid pulses.
  - If rw=1 and valid: regs[addr]<=byte; wr_strobe pulses; wr_addr/wr_data update, all in the same clk.
  - Then go to HOLD.
- HOLD: further sclk edges ignored; miso=0.
- cs_n synced high from any state:
  - return to IDLE next clk.
  - frame_err pulses if state was CMD or DATA with bit_cnt!=0, or if state was CMD with bit_cnt=0 after at least one edge.
  - A partial data byte never writes.
- miso:
  - miso_oe = ~cs_n_sync.
  - miso = tx_shift[7] in DATA, 0 otherwise.
  - Bit 7 is valid before the first data-byte rise.
- Write to an invalid address: no register change, no wr_strobe; rx_valid still pulses.
- Simultaneous local read of regs_flat with SPI write: regs_flat shows the new value from the clk after the write.

Optional Feature:
SPI_AUTOINC_EN
- Defined: after each data byte, DATA repeats instead of entering HOLD.
  - addr increments, wrapping NREGS-1 -> 0.
  - valid is recomputed and tx_shift reloads for reads.
  - Each byte gets its own rx_valid and wr_strobe.
  - Frame ends only on cs_n high; frame_err only for a partial byte.
- Undefined: single-byte frame as above; HOLD logic is present.

Test Plan:
1. Write: cs_n low, mosi 0x82 then 0x5A, cs_n high.
   -> one wr_strobe, wr_addr=2, wr_data=5A; regs_flat[23:16]=5A; rx_byte=5A; frame_err=0.
2. Read: after test 1, send 0x02 then 0x00.
   -> miso bits sampled on sclk rise = 0x5A; rx_byte=00; no wr_strobe; regs unchanged.
3. Abort: send 0x81, then 4 data bits, then cs_n high.
   -> frame_err one pulse; no wr_strobe; regs_flat[15:8]=00.
4. Invalid address (NREGS=4): write 0x85/0x77, then read 0x05.
   -> no wr_strobe; rx_valid pulses; read returns 0x00; regs unchanged.
5. Reset mid-frame: reset=0 after 10 sclk rises following test 1, then a fresh read of addr 2.
   -> all outputs 0 immediately; read returns RESET_VAL 00.
6. (SPI_AUTOINC_EN) Burst: send 0x83, 0x11, 0x22, then read 0x03 with 2 bytes.
   -> reg3=11, reg0=22, two wr_strobes; read returns 11 then 22.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// spi_slave_regfile: SPI mode-0 responder (MSB first) in front of a byte-wide
// register bank. sclk/cs_n/mosi are oversampled in the clk domain.
// Frame: command byte {rw, addr[6:0]} followed by a data byte.
// Optional build macro SPI_AUTOINC_EN: the data phase repeats with an
// auto-incrementing address until cs_n rises; otherwise the frame holds
// after one data byte.
module spi_slave_regfile #(
    parameter int         NREGS     = 4,
    parameter int         ADDR_W    = 2,
    parameter logic [7:0] RESET_VAL = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    output logic                 miso,
    output logic                 miso_oe,
    output logic [8*NREGS-1:0]   regs_flat,
    output logic                 wr_strobe,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [7:0]           wr_data,
    output logic [7:0]           rx_byte,
    output logic                 rx_valid,
    output logic                 frame_err
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, HOLD} state_t;

    state_t               state_q, state_d;
    logic [2:0]           sclk_sync_q, sclk_sync_d;
    logic [1:0]           cs_sync_q, cs_sync_d;
    logic [1:0]           mosi_sync_q, mosi_sync_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 edge_seen_q, edge_seen_d;
    logic [6:0]           rx_shift_q, rx_shift_d;
    logic [7:0]           tx_shift_q, tx_shift_d;
    logic                 rw_q, rw_d;
    logic [6:0]           addr_q, addr_d;
    logic                 valid_q, valid_d;
    logic [8*NREGS-1:0]   regs_q, regs_d;
    logic                 wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;
    logic [7:0]           rx_byte_q, rx_byte_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;

    logic                 sclk_rise, sclk_fall, cs_n_s, mosi_s, last_bit;
    logic [7:0]           rx_next;
    logic [6:0]           addr_inc;

    function automatic logic addr_ok(input logic [6:0] a);
        return ({25'd0, a} < 32'(NREGS));
    endfunction

    function automatic logic [7:0] reg_rd(input logic [8*NREGS-1:0] bank, input logic [6:0] a);
        logic [7:0] v;
        v = 8'h00;
        for (int i = 0; i < NREGS; i++) begin
            if (a == 7'(i)) v = bank[8*i +: 8];
        end
        return v;
    endfunction

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign cs_n_s    = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign rx_next   = {rx_shift_q, mosi_s};
    assign last_bit  = sclk_rise && (bit_cnt_q == 3'd7);
    assign addr_inc  = (addr_q == 7'(NREGS - 1)) ? 7'd0 : addr_q + 7'd1;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a synced cs_n high always wins and returns to IDLE
    always_comb begin
        state_d = state_q;
        if (cs_n_s) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = CMD;
                CMD:  if (last_bit) state_d = DATA;
`ifdef SPI_AUTOINC_EN
                DATA: state_d = DATA;
`else
                DATA: if (last_bit) state_d = HOLD;
`endif
                HOLD: state_d = HOLD;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values: synchronisers, shifters, register bank, pulses
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        cs_sync_d   = {cs_sync_q[0], cs_n};
        mosi_sync_d = {mosi_sync_q[0], mosi};
        bit_cnt_d   = bit_cnt_q;
        edge_seen_d = edge_seen_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        valid_d     = valid_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        if (cs_n_s) begin
            frame_err_d = ((state_q == CMD) && ((bit_cnt_q != 3'd0) || edge_seen_q)) ||
                          ((state_q == DATA) && (bit_cnt_q != 3'd0));
            bit_cnt_d   = 3'd0;
            edge_seen_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d   = 3'd0;
                    edge_seen_d = 1'b0;
                end
                CMD: begin
                    if (sclk_rise || sclk_fall) edge_seen_d = 1'b1;
                    if (sclk_rise) begin
                        rx_shift_d = rx_next[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                    end
                    if (last_bit) begin
                        rw_d       = rx_next[7];
                        addr_d     = rx_next[6:0];
                        valid_d    = addr_ok(rx_next[6:0]);
                        tx_shift_d = (!rx_next[7] && addr_ok(rx_next[6:0])) ?
                                     reg_rd(regs_q, rx_next[6:0]) : 8'h00;
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        rx_shift_d = rx_next[6:0];
                        bit_cnt_d  = bit_cnt_q + 3'd1;
                    end else if (sclk_fall && (bit_cnt_q != 3'd0)) begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                    if (last_bit) begin
                        rx_byte_d  = rx_next;
                        rx_valid_d = 1'b1;
                        if (rw_q && valid_q) begin
                            for (int i = 0; i < NREGS; i++) begin
                                if (addr_q == 7'(i)) regs_d[8*i +: 8] = rx_next;
                            end
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q[ADDR_W-1:0];
                            wr_data_d   = rx_next;
                        end
`ifdef SPI_AUTOINC_EN
                        addr_d     = addr_inc;
                        valid_d    = addr_ok(addr_inc);
                        tx_shift_d = (!rw_q && addr_ok(addr_inc)) ? reg_rd(regs_q, addr_inc) : 8'h00;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            bit_cnt_q   <= 3'd0;
            edge_seen_q <= 1'b0;
            rx_shift_q  <= 7'd0;
            tx_shift_q  <= 8'h00;
            rw_q        <= 1'b0;
            addr_q      <= 7'd0;
            valid_q     <= 1'b0;
            regs_q      <= {NREGS{RESET_VAL}};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            rx_byte_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            edge_seen_q <= edge_seen_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            valid_q     <= valid_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Output logic: miso only carries the transmit shifter during the data phase
    always_comb begin
        miso    = (state_q == DATA) ? tx_shift_q[7] : 1'b0;
        miso_oe = ~cs_n_s;
    end

    assign regs_flat = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_regfile.sv
// Directed testbench for spi_slave_regfile (NREGS=4, ADDR_W=2, RESET_VAL=0).
module tb_spi_slave_regfile;

    localparam int HALF = 6;

    logic        clk, reset, sclk, cs_n, mosi;
    logic        miso, miso_oe, wr_strobe, rx_valid, frame_err;
    logic [31:0] regs_flat;
    logic [1:0]  wr_addr;
    logic [7:0]  wr_data, rx_byte;

    spi_slave_regfile #(.NREGS(4), .ADDR_W(2), .RESET_VAL(8'h00)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .frame_err(frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running counts of clocks each pulse output is high
    int n_wr = 0, n_rxv = 0, n_ferr = 0;
    always @(negedge clk) begin
        if (wr_strobe) n_wr  <= n_wr + 1;
        if (rx_valid)  n_rxv <= n_rxv + 1;
        if (frame_err) n_ferr <= n_ferr + 1;
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic m);
        @(negedge clk);
        mosi = b;
        repeat (HALF) @(negedge clk);
        m = miso;
        sclk = 1'b1;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic m;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], m);
            rx[i] = m;
        end
    endtask

    task automatic cs_lo();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        check("miso_oe_selected", miso_oe, 1);
    endtask

    task automatic cs_hi();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
        check("miso_oe_deselected", miso_oe, 0);
    endtask

    task automatic frame2(input logic [7:0] b0, input logic [7:0] b1, output logic [7:0] r1);
        logic [7:0] r0;
        cs_lo();
        spi_byte(b0, r0);
        check("cmd_phase_miso", r0, 0);
        spi_byte(b1, r1);
        cs_hi();
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  dat;
        logic [7:0]  rd;
        int          wr;
        logic [7:0]  rx;
        logic [31:0] regs;
        logic [1:0]  wa;
        logic [7:0]  wd;
    } vec_t;

    vec_t        vecs[11];
    logic [7:0]  r, r1, r2;
    logic        m;
    logic [31:0] exp_regs;
    int          w0, v0, f0;

    initial begin
        vecs[0]  = '{8'h82, 8'h5A, 8'h00, 1, 8'h5A, 32'h005A0000, 2'd2, 8'h5A};
        vecs[1]  = '{8'h02, 8'h00, 8'h5A, 0, 8'h00, 32'h005A0000, 2'd2, 8'h5A};
        vecs[2]  = '{8'h85, 8'h77, 8'h00, 0, 8'h77, 32'h005A0000, 2'd2, 8'h5A};
        vecs[3]  = '{8'h05, 8'hFF, 8'h00, 0, 8'hFF, 32'h005A0000, 2'd2, 8'h5A};
        vecs[4]  = '{8'h80, 8'hC3, 8'h00, 1, 8'hC3, 32'h005A00C3, 2'd0, 8'hC3};
        vecs[5]  = '{8'h83, 8'h3C, 8'h00, 1, 8'h3C, 32'h3C5A00C3, 2'd3, 8'h3C};
        vecs[6]  = '{8'h00, 8'h00, 8'hC3, 0, 8'h00, 32'h3C5A00C3, 2'd3, 8'h3C};
        vecs[7]  = '{8'h03, 8'hA5, 8'h3C, 0, 8'hA5, 32'h3C5A00C3, 2'd3, 8'h3C};
        vecs[8]  = '{8'hFF, 8'h12, 8'h00, 0, 8'h12, 32'h3C5A00C3, 2'd3, 8'h3C};
        vecs[9]  = '{8'h7F, 8'h00, 8'h00, 0, 8'h00, 32'h3C5A00C3, 2'd3, 8'h3C};
        vecs[10] = '{8'h01, 8'h00, 8'h00, 0, 8'h00, 32'h3C5A00C3, 2'd3, 8'h3C};

        reset = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {miso, miso_oe, wr_strobe, rx_valid, frame_err, wr_addr, wr_data, rx_byte}, 0);
        check("reset_regs", regs_flat, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Two-byte frames from the vector table
        for (int i = 0; i < 11; i++) begin
            w0 = n_wr; v0 = n_rxv; f0 = n_ferr;
            frame2(vecs[i].cmd, vecs[i].dat, r);
            check($sformatf("v%0d_miso_byte", i), r, vecs[i].rd);
            check($sformatf("v%0d_wr_strobes", i), n_wr - w0, vecs[i].wr);
            check($sformatf("v%0d_rx_valids", i), n_rxv - v0, 1);
            check($sformatf("v%0d_frame_err", i), n_ferr - f0, 0);
            check($sformatf("v%0d_rx_byte", i), rx_byte, vecs[i].rx);
            check($sformatf("v%0d_regs", i), regs_flat, vecs[i].regs);
            check($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].wa);
            check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].wd);
        end
        exp_regs = 32'h3C5A00C3;

        // Abort inside the data byte: write 0x81 then only 4 data bits
        w0 = n_wr; v0 = n_rxv; f0 = n_ferr;
        cs_lo();
        spi_byte(8'h81, r);
        spi_bit(1'b1, m); spi_bit(1'b0, m); spi_bit(1'b1, m); spi_bit(1'b0, m);
        cs_hi();
        check("abort_data_frame_err", n_ferr - f0, 1);
        check("abort_data_wr_strobes", n_wr - w0, 0);
        check("abort_data_rx_valids", n_rxv - v0, 0);
        check("abort_data_reg1", regs_flat[15:8], 8'h00);
        check("abort_data_regs", regs_flat, exp_regs);

        // Abort inside the command byte after 3 bits
        f0 = n_ferr;
        cs_lo();
        spi_bit(1'b1, m); spi_bit(1'b0, m); spi_bit(1'b0, m);
        cs_hi();
        check("abort_cmd_frame_err", n_ferr - f0, 1);

        // Select/deselect with no sclk edges is not an error
        f0 = n_ferr;
        cs_lo();
        cs_hi();
        check("empty_frame_err", n_ferr - f0, 0);

        // Complete command byte with no data bits: clean end, no write
        w0 = n_wr; v0 = n_rxv; f0 = n_ferr;
        cs_lo();
        spi_byte(8'h82, r);
        cs_hi();
        check("cmd_only_frame_err", n_ferr - f0, 0);
        check("cmd_only_wr_strobes", n_wr - w0, 0);
        check("cmd_only_rx_valids", n_rxv - v0, 0);
        check("cmd_only_regs", regs_flat, exp_regs);

`ifdef SPI_AUTOINC_EN
        // Burst write reg3 then reg0 (wrap), then burst read them back
        w0 = n_wr; v0 = n_rxv; f0 = n_ferr;
        cs_lo();
        spi_byte(8'h83, r);
        spi_byte(8'h11, r);
        spi_byte(8'h22, r);
        cs_hi();
        exp_regs = 32'h115A0022;
        check("burst_wr_strobes", n_wr - w0, 2);
        check("burst_rx_valids", n_rxv - v0, 2);
        check("burst_frame_err", n_ferr - f0, 0);
        check("burst_regs", regs_flat, exp_regs);
        check("burst_wr_addr", wr_addr, 2'd0);
        check("burst_wr_data", wr_data, 8'h22);
        w0 = n_wr; v0 = n_rxv; f0 = n_ferr;
        cs_lo();
        spi_byte(8'h03, r);
        spi_byte(8'h00, r1);
        spi_byte(8'h00, r2);
        cs_hi();
        check("burst_read_byte0", r1, 8'h11);
        check("burst_read_byte1", r2, 8'h22);
        check("burst_read_wr_strobes", n_wr - w0, 0);
        check("burst_read_rx_valids", n_rxv - v0, 2);
        check("burst_read_frame_err", n_ferr - f0, 0);
`endif

        // Asynchronous reset after 10 sclk rises of a write frame
        cs_lo();
        spi_byte(8'h82, r);
        spi_bit(1'b1, m); spi_bit(1'b1, m);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midframe_reset_outputs", {miso, miso_oe, wr_strobe, rx_valid, frame_err, wr_addr, wr_data, rx_byte}, 0);
        check("midframe_reset_regs", regs_flat, 0);
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        w0 = n_wr;
        frame2(8'h02, 8'h00, r);
        check("post_reset_read", r, 8'h00);
        check("post_reset_regs", regs_flat, 0);
        check("post_reset_wr_strobes", n_wr - w0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
